writeback_reorder_buffer: RTL and testbench
===========================================

# writeback_reorder_buffer

Sits between the execution units and `register_file`'s write-back port. Accepts results that complete out of order and tags each with its dispatch slot. Retires them strictly in dispatch order as single-cycle `wb_*` pulses, so the register file's active list sees write-backs and commits in program order. One entry is allocated per renamed destination at decode; one write-back is issued per cycle at most.

## Interface
- `DATA_WIDTH`, 32, result width
- `PREG_WIDTH`, 6, physical register index width (64 physical regs)
- `INDEX_WIDTH`, 5, active-list index width; buffer depth = 2^INDEX_WIDTH
- `clk` in 1: the single clock
- `rst_n` in 1: asynchronous, active-low reset
- `flush` in 1: synchronous clear of all entries (mispredict/exception)
- `alloc_valid` in 1: decode requests an entry
- `alloc_preg` in PREG_WIDTH: `physical_rd_addr` from `register_file`
- `alloc_list_index` in INDEX_WIDTH: `active_list_index` from `register_file`
- `alloc_ready` out 1: entry available; combinational, equals !full
- `alloc_tag` out INDEX_WIDTH: slot granted (= tail); valid when `alloc_valid && alloc_ready`
- `cpl_valid` in 1: an execution unit delivers a result
- `cpl_tag` in INDEX_WIDTH: slot returned by `alloc_tag`
- `cpl_data` in DATA_WIDTH: result value
- `wb_write_enable` out 1: registered; one-cycle write-back pulse
- `wb_physical_write_addr` out PREG_WIDTH: registered; stored `alloc_preg`
- `wb_physical_write_data` out DATA_WIDTH: registered; stored `cpl_data`
- `wb_active_list_index` out INDEX_WIDTH: registered; stored `alloc_list_index`
- `count` out INDEX_WIDTH+1: occupied entries, for debug/perf

## Operation
- Each entry holds `valid`, `done`, `preg`, `list_index`, and `data`. The buffer keeps `head` and `tail` pointers of INDEX_WIDTH bits, wrapping modulo depth, plus `count` of INDEX_WIDTH+1 bits.
- **Allocate:** on `alloc_valid && alloc_ready`:
  - write `{valid=1, done=0, preg, list_index}` at `tail`;
  - increment `tail` and `count`.
- **Complete:** on `cpl_valid`, if `entry[cpl_tag].valid && !done`, set `done=1` and store `data`. Any other completion is ignored: invalid slot or duplicate.
- **Commit:** each cycle, if `entry[head].valid && done`:
  - load the `wb_*` registers from the entry and drive `wb_write_enable=1`;
  - clear `valid`;
  - increment `head` and decrement `count`.
  Otherwise `wb_write_enable=0`, and the other `wb_*` outputs hold their last values.
- **`alloc_preg == 0`** (write to r0): the entry is still allocated and committed in order. `wb_write_enable` still pulses; the register file ignores address 0.
- **Full:** full when `count == 2^INDEX_WIDTH`; empty when `count == 0`.
- **Allocate and commit in the same cycle:**
  - `count` is unchanged.
  - When full, `alloc_ready` stays low that cycle because it is based on the pre-edge `count`.
- **Completion to head in the same cycle:** a completion targeting `head` does not commit in that cycle; it commits the next cycle.
- **`flush`:** clears every `valid`/`done`, zeroes `head`, `tail`, `count` and `wb_write_enable`, and ignores the same-cycle alloc and cpl. It takes priority over all other events.

## Timing
- Reset (asynchronous, `rst_n` low) values:
  - all entries invalid;
  - `head`/`tail`/`count` = 0;
  - `wb_write_enable` = 0;
  - `wb_physical_write_addr`/`data`/`active_list_index` = 0;
  - `alloc_ready` = 1, `alloc_tag` = 0.
- Reset mid-operation discards all in-flight entries with no write-back.
- **Latency:** a completion sampled at edge N sets `done`. If the entry is at `head`, the commit decision is made at edge N+1 and `wb_write_enable` is high for the cycle after edge N+1. Minimum completion-to-write-back is 2 edges.
- **Throughput:** one commit per cycle when consecutive head entries are done. A burst of k done entries produces k back-to-back pulses.
- `alloc_tag` and `alloc_ready` are combinational from `tail`/`count` only, with no path from `alloc_valid`.

## Structure
- `defines.v` holds `DATA_BUS` and `PREG_BUS`, and adds `ROB_TAG_BUS` ([INDEX_WIDTH-1:0]) shared with the execution units.
- Single module; no sub-module is needed. Entry storage is a flop array, read combinationally at `head`.

## Test plan
- **In order:** after reset, allocate preg 32, 33, 34 (tags 0, 1, 2); complete tags 0, 1, 2 with 0xA, 0xB, 0xC on consecutive cycles. Required: three pulses `(32,0xA)`, `(33,0xB)`, `(34,0xC)`, each 2 cycles after its completion.
- **Out of order:** allocate tags 0–2; complete 2, then 1, then 0 (0x3, 0x2, 0x1). Required: no pulse until tag 0 completes, then three back-to-back pulses in order 0, 1, 2.
- **Full/wrap:** allocate 32 entries → `alloc_ready=0`, `count=32`. Complete tag 0; the cycle it commits, `alloc_ready` returns to 1 on the next cycle. Required: the next allocation gets tag 0, and later commits keep order across the wrap.
- **Flush:** with 5 entries (2 done) pending, pulse `flush`. Required: no `wb_write_enable` afterwards, `count=0`, and the next allocation gets tag 0.
- **Ignored completion:** complete an unallocated tag 7 with 0xDEAD, then complete a done tag twice. Required: no state change, and the second data value is not written back.
- **Async reset:** assert `rst_n` low mid-burst. Required: `wb_write_enable` drops immediately and all outputs equal their reset values before the next clock edge.

Source files
------------

// File: rtl/writeback_reorder_buffer_pkg.sv
// Shared widths and types for the write-back reorder buffer and the execution units
// that return completions tagged with its slot index.
package writeback_reorder_buffer_pkg;

    localparam int DATA_WIDTH_DEF  = 32;
    localparam int PREG_WIDTH_DEF  = 6;
    localparam int INDEX_WIDTH_DEF = 5;

    // Slot tag handed to an execution unit at dispatch and returned with its result
    typedef logic [INDEX_WIDTH_DEF-1:0] rob_tag_t;
    typedef logic [DATA_WIDTH_DEF-1:0]  data_bus_t;
    typedef logic [PREG_WIDTH_DEF-1:0]  preg_bus_t;

endpackage

// File: rtl/writeback_reorder_buffer.sv
// Collects out-of-order execution results and replays them to the register file
// write-back port strictly in dispatch order, one registered pulse per cycle.
module writeback_reorder_buffer
    import writeback_reorder_buffer_pkg::*;
#(
    parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter int PREG_WIDTH  = PREG_WIDTH_DEF,
    parameter int INDEX_WIDTH = INDEX_WIDTH_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   alloc_valid,
    input  logic [PREG_WIDTH-1:0]  alloc_preg,
    input  logic [INDEX_WIDTH-1:0] alloc_list_index,
    output logic                   alloc_ready,
    output logic [INDEX_WIDTH-1:0] alloc_tag,
    input  logic                   cpl_valid,
    input  logic [INDEX_WIDTH-1:0] cpl_tag,
    input  logic [DATA_WIDTH-1:0]  cpl_data,
    output logic                   wb_write_enable,
    output logic [PREG_WIDTH-1:0]  wb_physical_write_addr,
    output logic [DATA_WIDTH-1:0]  wb_physical_write_data,
    output logic [INDEX_WIDTH-1:0] wb_active_list_index,
    output logic [INDEX_WIDTH:0]   count
);

    localparam int DEPTH = 1 << INDEX_WIDTH;
    localparam logic [INDEX_WIDTH:0] FULL_COUNT = (INDEX_WIDTH+1)'(DEPTH);

    logic [DEPTH-1:0]       r_valid;
    logic [DEPTH-1:0]       r_done;
    logic [PREG_WIDTH-1:0]  r_preg       [DEPTH];
    logic [INDEX_WIDTH-1:0] r_list_index [DEPTH];
    logic [DATA_WIDTH-1:0]  r_data       [DEPTH];

    logic [INDEX_WIDTH-1:0] r_head;
    logic [INDEX_WIDTH-1:0] r_tail;
    logic [INDEX_WIDTH:0]   r_count;

    logic w_full;
    logic w_alloc;
    logic w_cpl;
    logic w_commit;

    // Ready/tag depend only on registered state so decode never sees a loop through alloc_valid
    assign w_full      = (r_count == FULL_COUNT);
    assign alloc_ready = !w_full;
    assign alloc_tag   = r_tail;
    assign count       = r_count;

    assign w_alloc  = alloc_valid && !w_full && !flush;
    assign w_cpl    = cpl_valid && r_valid[cpl_tag] && !r_done[cpl_tag] && !flush;
    assign w_commit = r_valid[r_head] && r_done[r_head] && !flush;

    // Alloc writes the tail slot and commit frees the head slot; they can only alias when
    // the buffer is empty (nothing to commit) or full (alloc refused), so no conflict.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: every sequential update uses <= so all reads in this block see pre-edge state.
            r_valid <= '0;
            r_done  <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_valid <= '0;
            r_done  <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_alloc) begin
                r_valid[r_tail] <= 1'b1;
                r_done[r_tail]  <= 1'b0;
                r_tail          <= r_tail + INDEX_WIDTH'(1);
            end
            if (w_cpl) begin
                r_done[cpl_tag] <= 1'b1;
            end
            if (w_commit) begin
                r_valid[r_head] <= 1'b0;
                r_head          <= r_head + INDEX_WIDTH'(1);
            end
            case ({w_alloc, w_commit})
                2'b10:   r_count <= r_count + (INDEX_WIDTH+1)'(1);
                2'b01:   r_count <= r_count - (INDEX_WIDTH+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // NOTE: payload storage is not reset; the valid/done bits alone decide whether a slot is live.
    always_ff @(posedge clk) begin
        if (w_alloc) begin
            r_preg[r_tail]       <= alloc_preg;
            r_list_index[r_tail] <= alloc_list_index;
        end
        if (w_cpl) begin
            r_data[cpl_tag] <= cpl_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_write_enable        <= 1'b0;
            wb_physical_write_addr <= '0;
            wb_physical_write_data <= '0;
            wb_active_list_index   <= '0;
        end else if (w_commit) begin
            wb_write_enable        <= 1'b1;
            wb_physical_write_addr <= r_preg[r_head];
            wb_physical_write_data <= r_data[r_head];
            wb_active_list_index   <= r_list_index[r_head];
        end else begin
            wb_write_enable <= 1'b0;
        end
    end

endmodule

// File: tb/tb_writeback_reorder_buffer.sv
// Directed bench for writeback_reorder_buffer: in-order, out-of-order, full/wrap,
// flush, ignored completions and asynchronous reset mid-burst.
module tb_writeback_reorder_buffer;
    import writeback_reorder_buffer_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        alloc_valid = 1'b0;
    logic [5:0]  alloc_preg = '0;
    logic [4:0]  alloc_list_index = '0;
    logic        alloc_ready;
    logic [4:0]  alloc_tag;
    logic        cpl_valid = 1'b0;
    logic [4:0]  cpl_tag = '0;
    logic [31:0] cpl_data = '0;
    logic        wb_write_enable;
    logic [5:0]  wb_physical_write_addr;
    logic [31:0] wb_physical_write_data;
    logic [4:0]  wb_active_list_index;
    logic [5:0]  count;

    int n_total = 0;
    int n_pass  = 0;

    writeback_reorder_buffer dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .flush                  (flush),
        .alloc_valid            (alloc_valid),
        .alloc_preg             (alloc_preg),
        .alloc_list_index       (alloc_list_index),
        .alloc_ready            (alloc_ready),
        .alloc_tag              (alloc_tag),
        .cpl_valid              (cpl_valid),
        .cpl_tag                (cpl_tag),
        .cpl_data               (cpl_data),
        .wb_write_enable        (wb_write_enable),
        .wb_physical_write_addr (wb_physical_write_addr),
        .wb_physical_write_data (wb_physical_write_data),
        .wb_active_list_index   (wb_active_list_index),
        .count                  (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_total++;
        assert (observed === expected) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    endtask

    // Inputs change 1 time unit after the edge, outputs are sampled there too
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_alloc(input logic v, input logic [5:0] preg, input logic [4:0] idx);
        alloc_valid      = v;
        alloc_preg       = preg;
        alloc_list_index = idx;
    endtask

    task automatic set_cpl(input logic v, input logic [4:0] tag, input logic [31:0] data);
        cpl_valid = v;
        cpl_tag   = tag;
        cpl_data  = data;
    endtask

    task automatic check_wb(input string tag, input logic [5:0] preg, input logic [31:0] data,
                            input logic [4:0] idx);
        check({tag, "_we"},   32'(wb_write_enable), 32'd1);
        check({tag, "_addr"}, 32'(wb_physical_write_addr), 32'(preg));
        check({tag, "_data"}, wb_physical_write_data, data);
        check({tag, "_idx"},  32'(wb_active_list_index), 32'(idx));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_we"},    32'(wb_write_enable), 32'd0);
        check({tag, "_addr"},  32'(wb_physical_write_addr), 32'd0);
        check({tag, "_data"},  wb_physical_write_data, 32'd0);
        check({tag, "_idx"},   32'(wb_active_list_index), 32'd0);
        check({tag, "_ready"}, 32'(alloc_ready), 32'd1);
        check({tag, "_tag"},   32'(alloc_tag), 32'd0);
        check({tag, "_count"}, 32'(count), 32'd0);
    endtask

    task automatic do_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    initial begin
        // ---- reset state
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // ---- in order: preg 32,33,34 -> tags 0,1,2
        for (int i = 0; i < 3; i++) begin
            check($sformatf("inord_tag%0d", i), 32'(alloc_tag), 32'(i));
            set_alloc(1'b1, 6'(32 + i), 5'(i));
            tick();
        end
        set_alloc(1'b0, '0, '0);
        check("inord_count3", 32'(count), 32'd3);
        set_cpl(1'b1, 5'd0, 32'hA);
        tick();
        check("inord_no_wb_yet", 32'(wb_write_enable), 32'd0);
        set_cpl(1'b1, 5'd1, 32'hB);
        tick();
        check_wb("inord_wb0", 6'd32, 32'hA, 5'd0);
        set_cpl(1'b1, 5'd2, 32'hC);
        tick();
        check_wb("inord_wb1", 6'd33, 32'hB, 5'd1);
        set_cpl(1'b0, '0, '0);
        tick();
        check_wb("inord_wb2", 6'd34, 32'hC, 5'd2);
        tick();
        check("inord_idle_we", 32'(wb_write_enable), 32'd0);
        check("inord_idle_addr_hold", 32'(wb_physical_write_addr), 32'd34);
        check("inord_empty", 32'(count), 32'd0);

        // ---- out of order: complete 2,1,0
        do_flush();
        for (int i = 0; i < 3; i++) begin
            check($sformatf("ooo_tag%0d", i), 32'(alloc_tag), 32'(i));
            set_alloc(1'b1, 6'(40 + i), 5'(10 + i));
            tick();
        end
        set_alloc(1'b0, '0, '0);
        set_cpl(1'b1, 5'd2, 32'h3);
        tick();
        check("ooo_wait_a", 32'(wb_write_enable), 32'd0);
        set_cpl(1'b1, 5'd1, 32'h2);
        tick();
        check("ooo_wait_b", 32'(wb_write_enable), 32'd0);
        set_cpl(1'b1, 5'd0, 32'h1);
        tick();
        check("ooo_wait_c", 32'(wb_write_enable), 32'd0);
        set_cpl(1'b0, '0, '0);
        tick();
        check_wb("ooo_wb0", 6'd40, 32'h1, 5'd10);
        tick();
        check_wb("ooo_wb1", 6'd41, 32'h2, 5'd11);
        tick();
        check_wb("ooo_wb2", 6'd42, 32'h3, 5'd12);
        tick();
        check("ooo_idle", 32'(wb_write_enable), 32'd0);

        // ---- full / wrap; slot 0 carries preg 0
        do_flush();
        for (int i = 0; i < 32; i++) begin
            check($sformatf("full_tag%0d", i), 32'(alloc_tag), 32'(i));
            set_alloc(1'b1, 6'(i), 5'(i));
            tick();
        end
        check("full_ready", 32'(alloc_ready), 32'd0);
        check("full_count", 32'(count), 32'd32);
        set_alloc(1'b1, 6'd50, 5'd20);
        set_cpl(1'b1, 5'd0, 32'h100);
        tick();
        check("full_alloc_refused", 32'(count), 32'd32);
        check("full_still_not_ready", 32'(alloc_ready), 32'd0);
        set_cpl(1'b0, '0, '0);
        tick();
        check_wb("full_wb_r0", 6'd0, 32'h100, 5'd0);
        check("full_count_after_commit", 32'(count), 32'd31);
        check("full_ready_back", 32'(alloc_ready), 32'd1);
        check("full_wrap_tag", 32'(alloc_tag), 32'd0);
        tick();
        set_alloc(1'b0, '0, '0);
        check("wrap_count", 32'(count), 32'd32);
        check("wrap_no_wb", 32'(wb_write_enable), 32'd0);
        set_cpl(1'b1, 5'd0, 32'h200);
        tick();
        for (int t = 31; t >= 1; t--) begin
            set_cpl(1'b1, 5'(t), 32'h100 + 32'(t));
            tick();
            check($sformatf("wrap_hold_%0d", t), 32'(wb_write_enable), 32'd0);
        end
        set_cpl(1'b0, '0, '0);
        for (int k = 1; k < 32; k++) begin
            tick();
            check_wb($sformatf("wrap_wb%0d", k), 6'(k), 32'h100 + 32'(k), 5'(k));
        end
        tick();
        check_wb("wrap_wb_slot0", 6'd50, 32'h200, 5'd20);
        tick();
        check("wrap_idle", 32'(wb_write_enable), 32'd0);
        check("wrap_empty", 32'(count), 32'd0);

        // ---- flush with 5 pending, 2 done; same-cycle alloc/cpl ignored
        for (int i = 0; i < 5; i++) begin
            set_alloc(1'b1, 6'(1 + i), 5'(i));
            tick();
        end
        set_alloc(1'b0, '0, '0);
        set_cpl(1'b1, 5'd2, 32'h22);
        tick();
        set_cpl(1'b1, 5'd3, 32'h33);
        tick();
        check("flush_pre_count", 32'(count), 32'd5);
        set_alloc(1'b1, 6'd9, 5'd9);
        set_cpl(1'b1, 5'd1, 32'h11);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        set_alloc(1'b0, '0, '0);
        check("flush_count", 32'(count), 32'd0);
        check("flush_we", 32'(wb_write_enable), 32'd0);
        check("flush_tag", 32'(alloc_tag), 32'd0);
        tick();
        set_cpl(1'b0, '0, '0);
        tick();
        check("flush_no_wb", 32'(wb_write_enable), 32'd0);
        check("flush_cpl_ignored", 32'(count), 32'd0);

        // ---- ignored completions: unallocated tag, duplicate
        set_alloc(1'b1, 6'd60, 5'd30);
        tick();
        set_alloc(1'b1, 6'd61, 5'd31);
        tick();
        set_alloc(1'b0, '0, '0);
        set_cpl(1'b1, 5'd7, 32'hDEAD);
        tick();
        check("ign_tag7_count", 32'(count), 32'd2);
        check("ign_tag7_we", 32'(wb_write_enable), 32'd0);
        set_cpl(1'b1, 5'd1, 32'h11);
        tick();
        set_cpl(1'b1, 5'd1, 32'h22);
        tick();
        check("ign_dup_we", 32'(wb_write_enable), 32'd0);
        set_cpl(1'b1, 5'd0, 32'h10);
        tick();
        set_cpl(1'b0, '0, '0);
        tick();
        check_wb("ign_wb0", 6'd60, 32'h10, 5'd30);
        tick();
        check_wb("ign_wb1", 6'd61, 32'h11, 5'd31);
        tick();
        check("ign_idle", 32'(wb_write_enable), 32'd0);
        check("ign_empty", 32'(count), 32'd0);

        // ---- asynchronous reset mid-burst (tags 2,3,4)
        for (int i = 0; i < 3; i++) begin
            set_alloc(1'b1, 6'(1 + i), 5'(i));
            tick();
        end
        set_alloc(1'b0, '0, '0);
        for (int i = 0; i < 3; i++) begin
            set_cpl(1'b1, 5'(2 + i), 32'h70 + 32'(i));
            tick();
        end
        set_cpl(1'b0, '0, '0);
        check_wb("burst_wb3", 6'd2, 32'h71, 5'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("post_rst_we_a", 32'(wb_write_enable), 32'd0);
        tick();
        check("post_rst_we_b", 32'(wb_write_enable), 32'd0);
        check("post_rst_count", 32'(count), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
